// File: rtl/ysyx_210544_mem_stage_pkg.sv
// Shared opcode codes, access sizes, FSM states and byte-lane helpers for the memory stage.
package ysyx_210544_mem_stage_pkg;

    localparam logic [7:0] INST_LB  = 8'h01;
    localparam logic [7:0] INST_LH  = 8'h02;
    localparam logic [7:0] INST_LW  = 8'h03;
    localparam logic [7:0] INST_LD  = 8'h04;
    localparam logic [7:0] INST_LBU = 8'h05;
    localparam logic [7:0] INST_LHU = 8'h06;
    localparam logic [7:0] INST_LWU = 8'h07;
    localparam logic [7:0] INST_SB  = 8'h08;
    localparam logic [7:0] INST_SH  = 8'h09;
    localparam logic [7:0] INST_SW  = 8'h0A;
    localparam logic [7:0] INST_SD  = 8'h0B;

    typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} size_e;
    typedef enum logic [2:0] {IDLE, REQ0, RSP0, REQ1, RSP1, DONE} state_e;

    // Byte mask and lane-shifted data spanning two consecutive 8-byte beats.
    typedef struct packed {
        logic [15:0]  mask;
        logic [127:0] data;
    } beat_t;

    function automatic logic op_is_mem(input logic [7:0] op);
        return (op >= INST_LB) && (op <= INST_SD);
    endfunction

    function automatic logic op_is_load(input logic [7:0] op);
        return (op >= INST_LB) && (op <= INST_LWU);
    endfunction

    function automatic logic op_signed(input logic [7:0] op);
        return (op == INST_LB) || (op == INST_LH) || (op == INST_LW);
    endfunction

    function automatic size_e op_size(input logic [7:0] op);
        case (op)
            INST_LB, INST_LBU, INST_SB: return SZ_B;
            INST_LH, INST_LHU, INST_SH: return SZ_H;
            INST_LW, INST_LWU, INST_SW: return SZ_W;
            default:                    return SZ_D;
        endcase
    endfunction

    function automatic logic [3:0] size_bytes(input size_e s);
        return 4'd1 << s;
    endfunction

    function automatic logic crosses(input logic [2:0] off, input size_e s);
        return ({1'b0, off} + size_bytes(s)) > 4'd8;
    endfunction

    function automatic beat_t make_beats(input logic [2:0] off, input logic [63:0] wdata,
                                         input size_e s);
        beat_t b;
        b.mask = ((16'd1 << size_bytes(s)) - 16'd1) << off;
        b.data = {64'd0, wdata} << {off, 3'b000};
        return b;
    endfunction

endpackage

// File: rtl/ysyx_210544_mem_stage_ld_align.sv
// Load aligner: shifts the two-beat read window down by the byte offset and extends to 64 bits.
module ysyx_210544_ld_align
    import ysyx_210544_mem_stage_pkg::*;
(
    input  logic [127:0] data,
    input  logic [2:0]   off,
    input  size_e        size,
    input  logic         sgn,
    output logic [63:0]  result
);

    logic [63:0] v;

    assign v = 64'(data >> {off, 3'b000});

    always_comb begin
        result = v;
        case (size)
            SZ_B: result = sgn ? {{56{v[7]}},  v[7:0]}  : {56'd0, v[7:0]};
            SZ_H: result = sgn ? {{48{v[15]}}, v[15:0]} : {48'd0, v[15:0]};
            SZ_W: result = sgn ? {{32{v[31]}}, v[31:0]} : {32'd0, v[31:0]};
            default: result = v;
        endcase
    end

endmodule

// File: rtl/ysyx_210544_mem_stage.sv
// Memory-access stage: one- or two-beat bus transaction for loads/stores, pass-through otherwise.
module ysyx_210544_mem_stage
    import ysyx_210544_mem_stage_pkg::*;
#(
    parameter logic [63:0] MMIO_LIMIT = 64'h8000_0000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        ack,
    output logic        req,
    input  logic [7:0]  i_inst_opcode,
    input  logic [63:0] i_addr,
    input  logic [63:0] i_wdata,
    input  logic [63:0] i_rd_wdata,
    output logic [63:0] o_rd_wdata,
    output logic        o_mem_skip_cmt,
    output logic        o_bus_valid,
    input  logic        i_bus_ready,
    output logic [63:0] o_bus_addr,
    output logic        o_bus_wen,
    output logic [63:0] o_bus_wdata,
    output logic [7:0]  o_bus_wstrb,
    input  logic        i_bus_rsp_valid,
    input  logic [63:0] i_bus_rdata
);

    state_e      state, state_n;
    logic        accept, in_mem, in_load;
    size_e       in_size;
    beat_t       beat_in;
    logic        load_q, sgn_q, two_q;
    size_e       size_q;
    logic [2:0]  off_q;
    logic [7:0]  strb1_q;
    logic [63:0] wdata1_q, rdata0_q, align_res;
    logic [127:0] align_data;

    assign in_mem  = op_is_mem(i_inst_opcode);
    assign in_load = op_is_load(i_inst_opcode);
    assign in_size = op_size(i_inst_opcode);
    assign beat_in = make_beats(i_addr[2:0], i_wdata, in_size);
    assign accept  = ena && ((state == IDLE) || ((state == DONE) && ack));

    // Single-beat loads see only the live response; the second beat pairs it with the first.
    assign align_data = (state == RSP1) ? {i_bus_rdata, rdata0_q} : {64'd0, i_bus_rdata};

    ysyx_210544_ld_align u_ld_align (
        .data   (align_data),
        .off    (off_q),
        .size   (size_q),
        .sgn    (sgn_q),
        .result (align_res)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = in_mem ? REQ0 : DONE;
            REQ0: if (i_bus_ready) state_n = RSP0;
            RSP0: if (i_bus_rsp_valid) state_n = two_q ? REQ1 : DONE;
            REQ1: if (i_bus_ready) state_n = RSP1;
            RSP1: if (i_bus_rsp_valid) state_n = DONE;
            DONE: if (ack) state_n = accept ? (in_mem ? REQ0 : DONE) : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            req            <= 1'b0;
            o_rd_wdata     <= 64'd0;
            o_mem_skip_cmt <= 1'b0;
            o_bus_valid    <= 1'b0;
            o_bus_wen      <= 1'b0;
            o_bus_addr     <= 64'd0;
            o_bus_wdata    <= 64'd0;
            o_bus_wstrb    <= 8'd0;
            load_q         <= 1'b0;
            sgn_q          <= 1'b0;
            two_q          <= 1'b0;
            size_q         <= SZ_B;
            off_q          <= 3'd0;
            strb1_q        <= 8'd0;
            wdata1_q       <= 64'd0;
            rdata0_q       <= 64'd0;
        end else begin
            state <= state_n;
            case (state)
                IDLE, DONE: begin
                    if ((state == DONE) && ack) req <= 1'b0;
                    if (accept) begin
                        load_q   <= in_load;
                        sgn_q    <= op_signed(i_inst_opcode);
                        size_q   <= in_size;
                        off_q    <= i_addr[2:0];
                        two_q    <= crosses(i_addr[2:0], in_size);
                        strb1_q  <= in_load ? 8'd0  : beat_in.mask[15:8];
                        wdata1_q <= in_load ? 64'd0 : beat_in.data[127:64];
                        if (in_mem) begin
                            o_bus_valid    <= 1'b1;
                            o_bus_wen      <= !in_load;
                            o_bus_addr     <= {i_addr[63:3], 3'b000};
                            o_bus_wstrb    <= in_load ? 8'd0  : beat_in.mask[7:0];
                            o_bus_wdata    <= in_load ? 64'd0 : beat_in.data[63:0];
                            o_mem_skip_cmt <= i_addr < MMIO_LIMIT;
                            req            <= 1'b0;
                        end else begin
                            o_rd_wdata     <= i_rd_wdata;
                            o_mem_skip_cmt <= 1'b0;
                            req            <= 1'b1;
                        end
                    end
                end
                REQ0, REQ1: begin
                    if (i_bus_ready) begin
                        o_bus_valid <= 1'b0;
                        o_bus_wen   <= 1'b0;
                    end
                end
                RSP0: begin
                    if (i_bus_rsp_valid) begin
                        rdata0_q <= i_bus_rdata;
                        if (two_q) begin
                            o_bus_valid <= 1'b1;
                            o_bus_wen   <= !load_q;
                            o_bus_addr  <= o_bus_addr + 64'd8;
                            o_bus_wstrb <= strb1_q;
                            o_bus_wdata <= wdata1_q;
                        end else begin
                            req        <= 1'b1;
                            o_rd_wdata <= load_q ? align_res : 64'd0;
                        end
                    end
                end
                RSP1: begin
                    if (i_bus_rsp_valid) begin
                        req        <= 1'b1;
                        o_rd_wdata <= load_q ? align_res : 64'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_210544_mem_stage.sv
// Bench for the memory stage: byte-addressed memory model behind a randomized bus responder.
module tb_ysyx_210544_mem_stage;
    import ysyx_210544_mem_stage_pkg::*;

    localparam logic [7:0] OP_ADD = 8'h20;
    localparam logic [7:0] OP_SUB = 8'h33;

    logic        clk = 1'b0;
    logic        rst, ena, ack, req;
    logic [7:0]  i_inst_opcode;
    logic [63:0] i_addr, i_wdata, i_rd_wdata, o_rd_wdata;
    logic        o_mem_skip_cmt, o_bus_valid, i_bus_ready, o_bus_wen, i_bus_rsp_valid;
    logic [63:0] o_bus_addr, o_bus_wdata, i_bus_rdata;
    logic [7:0]  o_bus_wstrb;

    int compared = 0;
    int mismatched = 0;
    int ready_mode = 0;   // 0 random, 1 always, 2 never
    int rsp_mode = 0;     // 0 random, 1 immediate, 2 never

    typedef struct {
        logic [63:0] addr;
        logic        wen;
        logic [7:0]  strb;
        logic [63:0] wdata;
    } bus_beat_t;

    bus_beat_t   beats[$];
    logic [63:0] rsp_q[$];
    logic [7:0]  bus_mem [logic [63:0]];
    logic [7:0]  ref_mem [logic [63:0]];

    ysyx_210544_mem_stage dut (
        .clk(clk), .rst(rst), .ena(ena), .ack(ack), .req(req),
        .i_inst_opcode(i_inst_opcode), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rd_wdata(i_rd_wdata), .o_rd_wdata(o_rd_wdata), .o_mem_skip_cmt(o_mem_skip_cmt),
        .o_bus_valid(o_bus_valid), .i_bus_ready(i_bus_ready), .o_bus_addr(o_bus_addr),
        .o_bus_wen(o_bus_wen), .o_bus_wdata(o_bus_wdata), .o_bus_wstrb(o_bus_wstrb),
        .i_bus_rsp_valid(i_bus_rsp_valid), .i_bus_rdata(i_bus_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input logic [63:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] bus_byte(input logic [63:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [63:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [63:0] a, input logic [7:0] b);
        bus_mem[a] = b;
        ref_mem[a] = b;
    endtask

    // Bus slave: decides ready for the coming edge, answers strictly after acceptance.
    initial begin
        logic        r;
        logic [63:0] word;
        i_bus_ready = 1'b0;
        i_bus_rsp_valid = 1'b0;
        i_bus_rdata = 64'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rsp_q.delete();
                i_bus_rsp_valid = 1'b0;
                i_bus_ready = 1'b0;
            end else begin
                if (rsp_q.size() > 0 &&
                    (rsp_mode == 1 || (rsp_mode == 0 && $urandom_range(0, 2) != 0))) begin
                    i_bus_rsp_valid = 1'b1;
                    i_bus_rdata = rsp_q.pop_front();
                end else begin
                    i_bus_rsp_valid = 1'b0;
                    i_bus_rdata = {$urandom, $urandom};
                end
                r = (ready_mode == 1) || (ready_mode == 0 && $urandom_range(0, 1) == 1);
                i_bus_ready = r;
                if (o_bus_valid && r) begin
                    beats.push_back('{o_bus_addr, o_bus_wen, o_bus_wstrb, o_bus_wdata});
                    word = 64'd0;
                    for (int i = 0; i < 8; i++) begin
                        if (o_bus_wen && o_bus_wstrb[i]) bus_mem[o_bus_addr + 64'(i)] = o_bus_wdata[8*i +: 8];
                        word[8*i +: 8] = bus_byte(o_bus_addr + 64'(i));
                    end
                    rsp_q.push_back(o_bus_wen ? {$urandom, $urandom} : word);
                end
            end
        end
    end

    function automatic int ref_nbytes(input logic [7:0] op);
        case (op)
            INST_LB, INST_LBU, INST_SB: return 1;
            INST_LH, INST_LHU, INST_SH: return 2;
            INST_LW, INST_LWU, INST_SW: return 4;
            INST_LD, INST_SD:           return 8;
            default:                    return 0;
        endcase
    endfunction

    // Reference: loads read n little-endian bytes, stores write them; others pass through.
    task automatic model(input logic [7:0] op, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] rdw, output logic [63:0] exp_rd, output logic exp_skip);
        int n = ref_nbytes(op);
        logic [63:0] v = 64'd0;
        bit is_st = op inside {INST_SB, INST_SH, INST_SW, INST_SD};
        bit sx = op inside {INST_LB, INST_LH, INST_LW};
        exp_skip = (n != 0) && (addr < 64'h8000_0000);
        if (n == 0) begin
            exp_rd = rdw;
        end else if (is_st) begin
            for (int i = 0; i < n; i++) ref_mem[addr + 64'(i)] = wdata[8*i +: 8];
            exp_rd = 64'd0;
        end else begin
            for (int i = 0; i < n; i++) v[8*i +: 8] = ref_byte(addr + 64'(i));
            if (sx && v[8*n-1]) for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
            exp_rd = v;
        end
    endtask

    task automatic start(input logic [7:0] op, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] rdw);
        @(negedge clk);
        ena = 1'b1; i_inst_opcode = op; i_addr = addr; i_wdata = wdata; i_rd_wdata = rdw;
        @(negedge clk);
        ena = 1'b0; i_inst_opcode = 8'($urandom); i_addr = {$urandom, $urandom};
        i_wdata = {$urandom, $urandom}; i_rd_wdata = {$urandom, $urandom};
    endtask

    task automatic wait_req(output int lat);
        lat = 1;
        while (!req && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("req_rise", 128'(req), 128'(1'b1));
    endtask

    task automatic ack_it(input int dly, input logic [63:0] exp_rd);
        repeat (dly) begin
            @(negedge clk);
            chk("hold_req", 128'(req), 128'(1'b1));
            chk("hold_rd", 128'(o_rd_wdata), 128'(exp_rd));
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("req_fall", 128'(req), 128'(1'b0));
    endtask

    task automatic memcheck(input logic [63:0] addr);
        logic [63:0]  base = {addr[63:3], 3'b000};
        logic [127:0] a, b;
        for (int i = 0; i < 16; i++) begin
            a[8*i +: 8] = bus_byte(base + 64'(i));
            b[8*i +: 8] = ref_byte(base + 64'(i));
        end
        chk("mem_image", a, b);
    endtask

    task automatic run_op(input logic [7:0] op, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [63:0] rdw, input int dly, input int exp_lat);
        logic [63:0] exp_rd;
        logic        exp_skip;
        int          lat;
        model(op, addr, wdata, rdw, exp_rd, exp_skip);
        beats.delete();
        start(op, addr, wdata, rdw);
        wait_req(lat);
        if (exp_lat > 0) chk("latency", 128'(lat), 128'(exp_lat));
        chk("rd_wdata", 128'(o_rd_wdata), 128'(exp_rd));
        chk("skip_cmt", 128'(o_mem_skip_cmt), 128'(exp_skip));
        ack_it(dly, exp_rd);
        if (op inside {INST_SB, INST_SH, INST_SW, INST_SD}) memcheck(addr);
    endtask

    initial begin
        bus_beat_t   b0, b1;
        logic [63:0] exp_rd;
        logic        exp_skip;
        int          lat, k;
        logic [7:0]  ops [13] = '{INST_LB, INST_LH, INST_LW, INST_LD, INST_LBU, INST_LHU,
                                  INST_LWU, INST_SB, INST_SH, INST_SW, INST_SD, OP_ADD, OP_SUB};

        rst = 1'b1; ena = 1'b0; ack = 1'b0; i_inst_opcode = 8'd0;
        i_addr = 64'd0; i_wdata = 64'd0; i_rd_wdata = 64'd0;
        repeat (3) @(negedge clk);
        chk("rst_req", 128'(req), 128'(1'b0));
        chk("rst_valid", 128'(o_bus_valid), 128'(1'b0));
        chk("rst_rd", 128'(o_rd_wdata), 128'(64'd0));
        chk("rst_bus", {o_bus_addr, o_bus_wdata}, 128'd0);
        chk("rst_misc", 128'({o_bus_wen, o_mem_skip_cmt, o_bus_wstrb}), 128'd0);
        rst = 1'b0;

        // Non-memory op: one-cycle latency, no bus traffic.
        run_op(OP_ADD, 64'd0, 64'd0, 64'h1234, 0, 1);
        chk("add_no_bus", 128'(beats.size()), 128'd0);

        // One-beat LW with zero-wait bus.
        ready_mode = 1; rsp_mode = 1;
        for (int i = 0; i < 8; i++) poke(64'h8000_0000 + 64'(i), 8'(64'h8765_4321_0000_0000 >> (8*i)));
        run_op(INST_LW, 64'h8000_0004, 64'd0, 64'd0, 0, 3);
        chk("lw_value", 128'(o_rd_wdata), 128'(64'hFFFF_FFFF_8765_4321));
        chk("lw_beats", 128'(beats.size()), 128'd1);
        if (beats.size() == 1) begin
            b0 = beats[0];
            chk("lw_addr", 128'(b0.addr), 128'(64'h8000_0000));
            chk("lw_strb", 128'(b0.strb), 128'd0);
        end
        ready_mode = 0; rsp_mode = 0;

        // Two-beat SD crossing an 8-byte boundary.
        run_op(INST_SD, 64'h8000_0006, 64'h1122_3344_5566_7788, 64'd0, 0, 0);
        chk("sd_beats", 128'(beats.size()), 128'd2);
        if (beats.size() == 2) begin
            b0 = beats[0]; b1 = beats[1];
            chk("sd_b0", {b0.addr, 8'(b0.strb), 16'(b0.wdata[63:48])},
                {64'h8000_0000, 8'hC0, 16'h7788});
            chk("sd_b1", {b1.addr, 8'(b1.strb), 48'(b1.wdata[47:0])},
                {64'h8000_0008, 8'h3F, 48'h1122_3344_5566});
        end

        // Two-beat LHU.
        poke(64'h8000_0007, 8'hAB);
        poke(64'h8000_0008, 8'hCD);
        run_op(INST_LHU, 64'h8000_0007, 64'd0, 64'd0, 0, 0);
        chk("lhu_value", 128'(o_rd_wdata), 128'(64'hCDAB));
        chk("lhu_beats", 128'(beats.size()), 128'd2);

        // Bus stalls in REQ0: request fields must hold.
        ready_mode = 2;
        model(INST_SW, 64'h8000_0102, 64'hDEAD_BEEF_CAFE_F00D, 64'd0, exp_rd, exp_skip);
        beats.delete();
        start(INST_SW, 64'h8000_0102, 64'hDEAD_BEEF_CAFE_F00D, 64'd0);
        repeat (5) begin
            chk("stall_req", {64'(o_bus_valid), o_bus_addr}, {64'd1, 64'h8000_0100});
            chk("stall_strb", 128'({o_bus_wen, o_bus_wstrb}), 128'({1'b1, 8'h3C}));
            @(negedge clk);
        end
        ready_mode = 0;
        wait_req(lat);
        chk("sw_rd", 128'(o_rd_wdata), 128'(exp_rd));
        ack_it(0, exp_rd);
        memcheck(64'h8000_0102);

        // Asynchronous reset while waiting for a response.
        ready_mode = 1; rsp_mode = 2;
        start(INST_LD, 64'h8000_0010, 64'd0, 64'd0);
        @(negedge clk);
        chk("pre_rst_addr", 128'(o_bus_addr), 128'(64'h8000_0010));
        #2 rst = 1'b1;
        rsp_q.delete();
        #1;
        chk("arst_ctl", 128'({req, o_bus_valid, o_bus_wen, o_mem_skip_cmt}), 128'd0);
        chk("arst_data", {o_rd_wdata, o_bus_addr}, 128'd0);
        chk("arst_wr", 128'({o_bus_wdata, o_bus_wstrb}), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        rsp_q.delete();
        ready_mode = 0; rsp_mode = 0;

        // MMIO load with delayed ack.
        run_op(INST_LBU, 64'h1000_0000, 64'd0, 64'd0, 3, 0);
        chk("mmio_skip", 128'(o_mem_skip_cmt), 128'(1'b1));

        // Back-to-back: ack and ena in the same cycle.
        start(OP_ADD, 64'd0, 64'd0, 64'hAAAA);
        wait_req(lat);
        ena = 1'b1; ack = 1'b1; i_inst_opcode = OP_SUB; i_rd_wdata = 64'hBBBB;
        @(negedge clk);
        ena = 1'b0; ack = 1'b0;
        chk("b2b_req", 128'(req), 128'(1'b1));
        chk("b2b_rd", 128'(o_rd_wdata), 128'(64'hBBBB));
        model(INST_LD, 64'h8000_0020, 64'd0, 64'd0, exp_rd, exp_skip);
        ena = 1'b1; ack = 1'b1; i_inst_opcode = INST_LD; i_addr = 64'h8000_0020;
        @(negedge clk);
        ena = 1'b0; ack = 1'b0;
        chk("b2b_mem_gap", 128'(req), 128'(1'b0));
        wait_req(lat);
        chk("b2b_ld", 128'(o_rd_wdata), 128'(exp_rd));
        ack_it(0, exp_rd);

        // Randomized traffic over both regions.
        for (int t = 0; t < 40; t++) begin
            k = $urandom_range(0, 12);
            run_op(ops[k], ($urandom_range(0, 1) == 1 ? 64'h8000_0000 : 64'h1000_0000) +
                   64'($urandom_range(0, 47)), {$urandom, $urandom}, {$urandom, $urandom},
                   $urandom_range(0, 2), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
